// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core on one shared memory port.
// Strobes are combinational from state (and mem_ready); counter and fault flags are registered.
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             br_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_addr_src,
   output logic             mem_we,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             rf_we,
   output logic             pc_write,
   output logic             pc_src,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             fault,
   output logic             illegal,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // wait_cnt only ever holds 0..MEM_TIMEOUT-1 before the fault fires.
   localparam int unsigned     WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
   logic               fault_q, fault_d;
   logic               illegal_q, illegal_d;
   logic               mem_wait;
   logic               is_store;
   logic               op_legal;

   assign is_store = (opcode == OP_STORE);
   assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || (opcode == OP_BRANCH);

   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      illegal_d     = illegal_q;
      wait_cnt_d    = wait_cnt_q;
      mem_wait      = 1'b0;
      mem_req       = 1'b0;
      mem_addr_src  = 1'b0;
      mem_we        = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      rf_we         = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      instr_retired = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else begin
               mem_wait = 1'b1;
            end
         end
         S_DECODE: begin
            if (op_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_FAULT;
               fault_d   = 1'b1;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_R, OP_I:        state_d = S_WB;
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_BRANCH: begin
                  pc_write      = 1'b1;
                  pc_src        = br_taken;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
               default: begin
                  // IR must be stable after DECODE; a change here is treated as illegal.
                  state_d   = S_FAULT;
                  fault_d   = 1'b1;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_src = 1'b1;
            mem_we       = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pc_write      = 1'b1;
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end else begin
                  mdr_write = 1'b1;
                  state_d   = S_WB;
               end
            end else begin
               mem_wait = 1'b1;
            end
         end
         S_WB: begin
            rf_we         = 1'b1;
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
            fault_d = 1'b1;
         end
      endcase

      // Ready on the threshold cycle was already taken above, so mem_wait excludes it.
      if (TIMEOUT_EN && mem_wait && (wait_cnt_q == WAIT_LAST)) begin
         state_d   = S_FAULT;
         fault_d   = 1'b1;
         illegal_d = 1'b0;
      end

      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (TIMEOUT_EN && mem_wait) begin
         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end

      if (rst) begin
         mem_req       = 1'b0;
         mem_addr_src  = 1'b0;
         mem_we        = 1'b0;
         ir_write      = 1'b0;
         mdr_write     = 1'b0;
         rf_we         = 1'b0;
         pc_write      = 1'b0;
         pc_src        = 1'b0;
         instr_retired = 1'b0;
      end
   end

   assign retired_cnt_d = retired_cnt_q + CNT_W'(instr_retired);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FETCH;
         wait_cnt_q    <= '0;
         retired_cnt_q <= '0;
         fault_q       <= 1'b0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         retired_cnt_q <= retired_cnt_d;
         fault_q       <= fault_d;
         illegal_q     <= illegal_d;
      end
   end

   assign retired_cnt = retired_cnt_q;
   assign fault       = fault_q;
   assign illegal     = illegal_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: an instruction-level model expands each instruction into
// its expected per-cycle phases and strobes; a second instance with CNT_W=4 covers counter wrap.
module tb_multicycle_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, br_taken, mem_ready;
   logic [6:0] opcode;

   logic        mem_req, mem_addr_src, mem_we, ir_write, mdr_write, rf_we, pc_write, pc_src, instr_retired;
   logic [31:0] retired_cnt;
   logic        fault, illegal;
   logic [2:0]  state_dbg;

   logic        mem_req4, mem_addr_src4, mem_we4, ir_write4, mdr_write4, rf_we4, pc_write4, pc_src4, instr_retired4;
   logic [3:0]  retired_cnt4;
   logic        fault4, illegal4;
   logic [2:0]  state_dbg4;

   multicycle_sequencer dut (
      .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_addr_src(mem_addr_src), .mem_we(mem_we), .ir_write(ir_write),
      .mdr_write(mdr_write), .rf_we(rf_we), .pc_write(pc_write), .pc_src(pc_src),
      .instr_retired(instr_retired), .retired_cnt(retired_cnt), .fault(fault),
      .illegal(illegal), .state_dbg(state_dbg)
   );

   multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req4), .mem_addr_src(mem_addr_src4), .mem_we(mem_we4), .ir_write(ir_write4),
      .mdr_write(mdr_write4), .rf_we(rf_we4), .pc_write(pc_write4), .pc_src(pc_src4),
      .instr_retired(instr_retired4), .retired_cnt(retired_cnt4), .fault(fault4),
      .illegal(illegal4), .state_dbg(state_dbg4)
   );

   logic [8:0] strb, strb4;
   assign strb  = {mem_req, mem_addr_src, mem_we, ir_write, mdr_write, rf_we, pc_write, pc_src, instr_retired};
   assign strb4 = {mem_req4, mem_addr_src4, mem_we4, ir_write4, mdr_write4, rf_we4, pc_write4, pc_src4, instr_retired4};

   localparam logic [8:0] REQ = 9'h100, ASRC = 9'h080, WE = 9'h040, IRW = 9'h020, MDR = 9'h010;
   localparam logic [8:0] RFW = 9'h008, PCW = 9'h004, PCS = 9'h002, RET = 9'h001;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;

   localparam logic [2:0] P_FETCH = 3'd0, P_DECODE = 3'd1, P_EXEC = 3'd2, P_MEM = 3'd3, P_WB = 3'd4, P_FAULT = 3'd5;

   typedef struct packed {
      logic        rst;
      logic [6:0]  opc;
      logic        br;
      logic        rdy;
      logic [2:0]  st;
      logic [8:0]  strb;
      logic [31:0] cnt;
      logic        flt;
      logic        ill;
   } cyc_t;

   cyc_t        q[$];
   logic [31:0] m_cnt;
   logic        m_flt, m_ill;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [6:0] rnd7();
      return 7'($urandom_range(0, 127));
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic legal(input logic [6:0] o);
      return (o == OP_R) || (o == OP_I) || (o == OP_LOAD) || (o == OP_STORE) || (o == OP_BRANCH);
   endfunction

   // One expected cycle; registered expectations are the model values before this cycle's edge.
   function automatic void push(input logic r, input logic [6:0] o, input logic b, input logic rd,
                                input logic [2:0] st, input logic [8:0] s);
      cyc_t c;
      c.rst = r; c.opc = o; c.br = b; c.rdy = rd; c.st = st; c.strb = s;
      c.cnt = m_cnt; c.flt = m_flt; c.ill = m_ill;
      q.push_back(c);
      if (!r && s[0]) m_cnt = m_cnt + 1;
   endfunction

   function automatic void enter_fault(input logic ill);
      m_flt = 1'b1;
      m_ill = ill;
      for (int i = 0; i < 3; i++) push(1'b0, rnd7(), rnd1(), rnd1(), P_FAULT, 9'h000);
   endfunction

   function automatic void add_reset(input logic [2:0] cur_st);
      push(1'b1, rnd7(), rnd1(), rnd1(), cur_st, 9'h000);
      m_cnt = 0; m_flt = 1'b0; m_ill = 1'b0;
      push(1'b1, rnd7(), rnd1(), rnd1(), P_FETCH, 9'h000);
   endfunction

   // fw / mw: un-ready cycles before ready in FETCH / MEM; 15 or more means timeout.
   function automatic void add_instr(input logic [6:0] opc, input logic br, input int fw,
                                     input int mw, input logic abort_in_mem);
      logic       st;
      logic [8:0] base;
      for (int i = 0; i < fw && i < 15; i++) push(1'b0, rnd7(), rnd1(), 1'b0, P_FETCH, REQ);
      if (fw >= 15) begin enter_fault(1'b0); return; end
      push(1'b0, rnd7(), rnd1(), 1'b1, P_FETCH, REQ | IRW);
      push(1'b0, opc, rnd1(), rnd1(), P_DECODE, 9'h000);
      if (!legal(opc)) begin enter_fault(1'b1); return; end
      if (opc == OP_BRANCH) begin
         push(1'b0, opc, br, rnd1(), P_EXEC, PCW | (br ? PCS : 9'h000) | RET);
         return;
      end
      push(1'b0, opc, rnd1(), rnd1(), P_EXEC, 9'h000);
      if (opc == OP_LOAD || opc == OP_STORE) begin
         st   = (opc == OP_STORE);
         base = REQ | ASRC | (st ? WE : 9'h000);
         if (abort_in_mem) begin
            push(1'b0, opc, rnd1(), 1'b0, P_MEM, base);
            add_reset(P_MEM);
            return;
         end
         for (int i = 0; i < mw && i < 15; i++) push(1'b0, opc, rnd1(), 1'b0, P_MEM, base);
         if (mw >= 15) begin enter_fault(1'b0); return; end
         if (st) begin
            push(1'b0, opc, rnd1(), 1'b1, P_MEM, base | PCW | RET);
            return;
         end
         push(1'b0, opc, rnd1(), 1'b1, P_MEM, base | MDR);
      end
      push(1'b0, opc, rnd1(), rnd1(), P_WB, RFW | PCW | RET);
   endfunction

   task automatic test_reset();
      rst = 1'b1; opcode = rnd7(); br_taken = 1'b1; mem_ready = 1'b1;
      @(posedge clk); @(negedge clk); #1;
      n_cmp++;
      if ({state_dbg, state_dbg4} !== {P_FETCH, P_FETCH}) begin
         n_bad++; $display("FAIL reset_state: got %0d/%0d want 0", state_dbg, state_dbg4);
      end
      n_cmp++;
      if ({strb, strb4} !== 18'h0) begin
         n_bad++; $display("FAIL reset_strobes: got %b/%b want all zero", strb, strb4);
      end
      n_cmp++;
      if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== 40'h0) begin
         n_bad++; $display("FAIL reset_regs: got cnt=%0d cnt4=%0d flt=%b ill=%b want zeros",
                           retired_cnt, retired_cnt4, fault, illegal);
      end
      m_cnt = 0; m_flt = 1'b0; m_ill = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_alu();
      cyc_t c; int k = 0;
      add_instr(OP_R, 1'b0, 0, 0, 1'b0);
      add_instr(OP_I, 1'b1, 2, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL alu_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL alu_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   task automatic test_load_wait();
      cyc_t c; int k = 0;
      add_instr(OP_LOAD, 1'b0, 0, 3, 1'b0);
      add_instr(OP_LOAD, 1'b1, 1, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL load_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL load_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   task automatic test_branch();
      cyc_t c; int k = 0;
      add_instr(OP_BRANCH, 1'b1, 0, 0, 1'b0);
      add_instr(OP_BRANCH, 1'b0, 0, 0, 1'b0);
      add_instr(OP_STORE, 1'b0, 0, 2, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL branch_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL branch_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      cyc_t c; int k = 0;
      add_instr(OP_R, 1'b0, 15, 0, 1'b0);
      add_reset(P_FAULT);
      add_instr(OP_I, 1'b0, 0, 0, 1'b0);
      add_instr(OP_LOAD, 1'b0, 0, 15, 1'b0);
      add_reset(P_FAULT);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL timeout_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL timeout_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   task automatic test_illegal_and_threshold();
      cyc_t c; int k = 0;
      add_instr(7'b0110111, 1'b0, 0, 0, 1'b0);
      add_reset(P_FAULT);
      add_instr(OP_R, 1'b0, 14, 0, 1'b0);
      add_instr(OP_STORE, 1'b0, 14, 14, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL illegal_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL illegal_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   task automatic test_store_abort_wrap();
      cyc_t c; int k = 0;
      add_instr(OP_R, 1'b0, 0, 0, 1'b0);
      add_instr(OP_STORE, 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 16; i++) add_instr(OP_BRANCH, rnd1(), 0, 0, 1'b0);
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL abort_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL abort_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
      #1;
      n_cmp++;
      if ({retired_cnt, retired_cnt4} !== {32'd16, 4'd0}) begin
         n_bad++; $display("FAIL wrap: got cnt=%0d cnt4=%0d want cnt=16 cnt4=0", retired_cnt, retired_cnt4);
      end
   endtask

   task automatic test_random();
      cyc_t c; int k = 0;
      logic [6:0] opc;
      int sel, fw, mw;
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1:    opc = OP_R;
            2:       opc = OP_I;
            3, 4:    opc = OP_LOAD;
            5:       opc = OP_STORE;
            6, 7:    opc = OP_BRANCH;
            default: begin
               opc = rnd7();
               while (legal(opc)) opc = rnd7();
               if (sel == 8) opc = OP_STORE;
            end
         endcase
         sel = $urandom_range(0, 19);
         fw = (sel < 12) ? 0 : (sel < 18) ? $urandom_range(1, 3) : (sel == 18) ? 14 : 15;
         sel = $urandom_range(0, 19);
         mw = (sel < 12) ? 0 : (sel < 18) ? $urandom_range(1, 3) : (sel == 18) ? 14 : 15;
         add_instr(opc, rnd1(), fw, mw, ($urandom_range(0, 11) == 0));
         if (m_flt) add_reset(P_FAULT);
      end
      while (q.size() > 0) begin
         c = q.pop_front();
         rst = c.rst; opcode = c.opc; br_taken = c.br; mem_ready = c.rdy; #1;
         n_cmp++;
         if ({state_dbg, strb, state_dbg4, strb4} !== {c.st, c.strb, c.st, c.strb}) begin
            n_bad++; $display("FAIL random_ctrl cyc%0d: got st=%0d strb=%b (w4 st=%0d strb=%b) want st=%0d strb=%b",
                              k, state_dbg, strb, state_dbg4, strb4, c.st, c.strb);
         end
         n_cmp++;
         if ({retired_cnt, retired_cnt4, fault, illegal, fault4, illegal4} !== {c.cnt, c.cnt[3:0], c.flt, c.ill, c.flt, c.ill}) begin
            n_bad++; $display("FAIL random_regs cyc%0d: got cnt=%0d cnt4=%0d flt=%b ill=%b want cnt=%0d flt=%b ill=%b",
                              k, retired_cnt, retired_cnt4, fault, illegal, c.cnt, c.flt, c.ill);
         end
         k++; @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1; opcode = 7'h00; br_taken = 1'b0; mem_ready = 1'b0;
      m_cnt = 0; m_flt = 1'b0; m_ill = 1'b0;
      test_reset();
      test_alu();
      test_load_wait();
      test_branch();
      test_timeout();
      test_illegal_and_threshold();
      test_store_abort_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
